nf_pwm_cap: RTL and testbench
=============================

NF_PWM_CAP -- requirements
Module: nf_pwm_cap

Interface
REQ-001 The block SHALL have parameter: cnt_width, 16, width of the period/high-time counters and result registers.
REQ-002 The block SHALL have port: pwm_clk  input  1  block clock; all logic and bus signals are synchronous to it.
REQ-003 The block SHALL have port: pwm_resetn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: addr  input  32  nf_router register address; addr[3:2] selects the register.
REQ-005 The block SHALL have port: we  input  1  register write strobe.
REQ-006 The block SHALL have port: wd  input  32  write data.
REQ-007 The block SHALL have port: rd  output  32  read data, combinational from addr, zero-extended.
REQ-008 The block SHALL have port: pwm_in  input  1  asynchronous PWM signal under measurement.
REQ-009 The block SHALL have port: irq  output  1  interrupt, registered, equal to STATUS.valid & CTRL.ie.

Function
REQ-010 The block SHALL map registers as addr[3:2]: 0 CTRL (bit0 en, bit1 ie, RW), 1 STATUS (bit0 valid, bit1 ovf, bit2 ovr, write-1-to-clear), 2 PERIOD (RO), 3 HIGH (RO); writes to RO registers SHALL be ignored.
REQ-011 The block SHALL synchronise pwm_in through 2 flops, then register once more for edge detection; rise = sync & ~prev, fall = ~sync & prev.
REQ-012 The block SHALL implement FSM states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-013 IDLE -> WAIT_RISE when CTRL.en=1; any state -> IDLE in the cycle after CTRL.en is written 0; counter cleared, PERIOD/HIGH retained.
REQ-014 WAIT_RISE -> MEAS_HIGH on rise; counter loaded with 1.
REQ-015 In MEAS_HIGH/MEAS_LOW the counter SHALL increment by 1 per pwm_clk cycle.
REQ-016 MEAS_HIGH -> MEAS_LOW on fall; high-time shadow <= current counter value.
REQ-017 MEAS_LOW -> MEAS_HIGH on rise; PERIOD <= counter, HIGH <= shadow, valid <= 1, counter <= 1 (back-to-back measurements, no lost period).
REQ-018 Result semantics: PERIOD = pwm_clk cycles between consecutive rise events; HIGH = cycles from rise to fall event.
REQ-019 If the counter equals all-ones in MEAS_HIGH/MEAS_LOW, the block SHALL set ovf, not update PERIOD/HIGH, and go to WAIT_RISE.
REQ-020 If a new result is latched while valid=1, the block SHALL set ovr and overwrite PERIOD/HIGH.
REQ-021 Simultaneous W1C and hardware set of the same status bit: set SHALL win.
REQ-022 Edge-to-result latency: rising edge on pwm_in to valid=1 SHALL be 3 pwm_clk cycles (without filter); irq one cycle later.

Reset
REQ-023 On pwm_resetn=0: FSM IDLE, counter/shadow/PERIOD/HIGH 0, CTRL 0, STATUS 0, synchroniser and filter flops 0, irq 0; rd reflects these values.
REQ-024 Reset assertion mid-measurement SHALL abort it with no partial result.

Configuration
REQ-025 With NF_PWM_CAP_FILTER_EN defined, a glitch filter SHALL follow the synchroniser: the filtered level changes only after the synchronised input is stable for PWM_CAP_FILT_LEN (3) consecutive cycles, adding 3 cycles of edge latency; pulses shorter than 3 cycles are discarded.
REQ-026 Without NF_PWM_CAP_FILTER_EN the synchroniser output SHALL feed edge detection directly; no filter flops exist.

Structure
REQ-027 A shared package nf_pwm_cap_pkg SHALL hold the FSM state enum, register index constants (CTRL/STATUS/PERIOD/HIGH), status bit positions and PWM_CAP_FILT_LEN.
REQ-028 The synchroniser + optional filter + edge detector SHALL be one sub-module, nf_pwm_cap_edge.

Verification
REQ-029 en=1, pwm_in 3 high / 5 low cycles repeated -> PERIOD=8, HIGH=3, valid=1 after second rise.
REQ-030 pwm_in held high with en=1 for 65535 cycles past a rise (cnt_width=16) -> ovf=1, PERIOD/HIGH unchanged, FSM WAIT_RISE.
REQ-031 Two results without clearing valid -> ovr=1, PERIOD/HIGH hold second result; write STATUS=0x7 -> STATUS=0.
REQ-032 ie=1, one completed period -> irq=1 one cycle after valid; W1C valid -> irq=0 next cycle.
REQ-033 With NF_PWM_CAP_FILTER_EN: 2-cycle glitch in a 10/10 waveform -> PERIOD=20, HIGH=10; without macro -> glitch produces a short measurement.
REQ-034 pwm_resetn pulsed low during MEAS_LOW -> all registers 0, no valid; en=0 mid-measurement -> IDLE, prior PERIOD retained.

Source files
------------

// File: rtl/nf_pwm_cap_pkg.sv
// nf_pwm_cap shared types and constants.
// FSM encoding, register map indices, status bits, filter length.
package nf_pwm_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEAS_HIGH = 2'd2,
    ST_MEAS_LOW  = 2'd3
  } pwm_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_HIGH   = 2'd3;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_OVR   = 2;

  localparam int PWM_CAP_FILT_LEN = 3;

endpackage

// File: rtl/nf_pwm_cap_edge.sv
// pwm_in synchroniser, optional glitch filter and edge detector.
// Filter is built only when NF_PWM_CAP_FILTER_EN is defined.
module nf_pwm_cap_edge
  import nf_pwm_cap_pkg::*;
(
  input  logic pwm_clk,
  input  logic pwm_resetn,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic level;
  logic prev;

  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef NF_PWM_CAP_FILTER_EN
  localparam int FCW = $clog2(PWM_CAP_FILT_LEN);

  logic [FCW-1:0] filt_cnt;
  logic           filt_q;

  // level follows sync2 only after FILT_LEN consecutive disagreeing cycles
  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      filt_cnt <= '0;
      filt_q   <= 1'b0;
    end else if (sync2 == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(PWM_CAP_FILT_LEN - 1)) begin
      filt_cnt <= '0;
      filt_q   <= sync2;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2;
`endif

  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) prev <= 1'b0;
    else             prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/nf_pwm_cap.sv
// PWM period / high-time capture peripheral on the nf_router bus.
// Optional input glitch filter: define NF_PWM_CAP_FILTER_EN.
module nf_pwm_cap
  import nf_pwm_cap_pkg::*;
#(
  parameter int cnt_width = 16
) (
  input  logic        pwm_clk,
  input  logic        pwm_resetn,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        pwm_in,
  output logic        irq
);

  pwm_state_e           state;
  logic [cnt_width-1:0] cnt;
  logic [cnt_width-1:0] shadow;
  logic [cnt_width-1:0] period;
  logic [cnt_width-1:0] high;
  logic                 ctrl_en;
  logic                 ctrl_ie;
  logic [2:0]           status;

  logic rise;
  logic fall;
  logic cnt_max;
  logic ctrl_wr;
  logic stat_wr;
  logic set_valid;
  logic set_ovf;
  logic set_ovr;
  logic unused_bits;

  nf_pwm_cap_edge u_edge (
    .pwm_clk    (pwm_clk),
    .pwm_resetn (pwm_resetn),
    .pwm_in     (pwm_in),
    .rise       (rise),
    .fall       (fall)
  );

  assign cnt_max = &cnt;
  assign ctrl_wr = we & (addr[3:2] == REG_CTRL);
  assign stat_wr = we & (addr[3:2] == REG_STATUS);
  assign unused_bits = ^{addr[31:4], addr[1:0], wd[31:3]};

  always_comb begin
    set_valid = 1'b0;
    set_ovf   = 1'b0;
    if (ctrl_en) begin
      unique case (state)
        ST_MEAS_HIGH: set_ovf = cnt_max;
        ST_MEAS_LOW: begin
          set_ovf   = cnt_max;
          set_valid = ~cnt_max & rise;
        end
        default: ;
      endcase
    end
  end

  assign set_ovr = set_valid & status[STAT_VALID];

  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_en <= wd[0];
      ctrl_ie <= wd[1];
    end
  end

  // hardware set takes priority over a same-cycle write-1-to-clear
  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status[STAT_VALID] <= set_valid |
        (status[STAT_VALID] & ~(stat_wr & wd[STAT_VALID]));
      status[STAT_OVF] <= set_ovf |
        (status[STAT_OVF] & ~(stat_wr & wd[STAT_OVF]));
      status[STAT_OVR] <= set_ovr |
        (status[STAT_OVR] & ~(stat_wr & wd[STAT_OVR]));
      irq <= status[STAT_VALID] & ctrl_ie;
    end
  end

  always_ff @(posedge pwm_clk or negedge pwm_resetn) begin
    if (!pwm_resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shadow <= '0;
      period <= '0;
      high   <= '0;
    end else if (!ctrl_en) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: state <= ST_WAIT_RISE;
        ST_WAIT_RISE: begin
          if (rise) begin
            state <= ST_MEAS_HIGH;
            cnt   <= cnt_width'(1);
          end
        end
        ST_MEAS_HIGH: begin
          if (cnt_max) begin
            state <= ST_WAIT_RISE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (fall) begin
              shadow <= cnt;
              state  <= ST_MEAS_LOW;
            end
          end
        end
        ST_MEAS_LOW: begin
          if (cnt_max) begin
            state <= ST_WAIT_RISE;
            cnt   <= '0;
          end else if (rise) begin
            period <= cnt;
            high   <= shadow;
            cnt    <= cnt_width'(1);
            state  <= ST_MEAS_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      (addr[3:2] == REG_CTRL):   rd[1:0] = {ctrl_ie, ctrl_en};
      (addr[3:2] == REG_STATUS): rd[2:0] = status;
      (addr[3:2] == REG_PERIOD): rd[cnt_width-1:0] = period;
      (addr[3:2] == REG_HIGH):   rd[cnt_width-1:0] = high;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nf_pwm_cap.sv
// Directed self-checking bench for nf_pwm_cap.
// Honors NF_PWM_CAP_FILTER_EN for latency and glitch expectations.
module tb_nf_pwm_cap;

  logic        pwm_clk = 1'b0;
  logic        pwm_resetn = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        pwm_in = 1'b0;
  logic        irq;

`ifdef NF_PWM_CAP_FILTER_EN
  localparam int EXTRA = 3;
  localparam logic [31:0] GL_PER = 32'd20;
  localparam logic [31:0] GL_HI  = 32'd10;
`else
  localparam int EXTRA = 0;
  localparam logic [31:0] GL_PER = 32'd14;
  localparam logic [31:0] GL_HI  = 32'd4;
`endif

  localparam logic [1:0] R_CTRL = 2'd0;
  localparam logic [1:0] R_STAT = 2'd1;
  localparam logic [1:0] R_PER  = 2'd2;
  localparam logic [1:0] R_HIGH = 2'd3;

  int checks = 0;
  int errors = 0;

  always #5 pwm_clk = ~pwm_clk;

  nf_pwm_cap #(.cnt_width(16)) dut (
    .pwm_clk    (pwm_clk),
    .pwm_resetn (pwm_resetn),
    .addr       (addr),
    .we         (we),
    .wd         (wd),
    .rd         (rd),
    .pwm_in     (pwm_in),
    .irq        (irq)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pwm_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [1:0] idx,
                       input logic [31:0] exp);
    addr = {28'd0, idx, 2'b00};
    #1;
    chk(tag, rd, exp);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] data);
    addr = {28'd0, idx, 2'b00};
    wd   = data;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  initial begin
    tick(3);
    rdchk("rst_ctrl", R_CTRL, 32'd0);
    rdchk("rst_status", R_STAT, 32'd0);
    rdchk("rst_period", R_PER, 32'd0);
    rdchk("rst_high", R_HIGH, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    pwm_resetn = 1'b1;
    tick();

    // 3 high / 5 low, plus result latency
    wr(R_CTRL, 32'd1);
    rdchk("ctrl_en", R_CTRL, 32'd1);
    tick(4);
    pwm_in = 1'b1; tick(3);
    pwm_in = 1'b0; tick(5);
    pwm_in = 1'b1; tick(2 + EXTRA);
    rdchk("lat_not_yet", R_STAT, 32'd0);
    tick();
    rdchk("lat_valid", R_STAT, 32'd1);
    rdchk("p8_period", R_PER, 32'd8);
    rdchk("p8_high", R_HIGH, 32'd3);
    chk("irq_ie0", {31'd0, irq}, 32'd0);

    // second result without clearing valid -> overrun
    tick();
    pwm_in = 1'b0; tick(6);
    pwm_in = 1'b1; tick(3 + EXTRA);
    rdchk("ovr_status", R_STAT, 32'd5);
    rdchk("ovr_period", R_PER, 32'd10 + EXTRA);
    rdchk("ovr_high", R_HIGH, 32'd4 + EXTRA);
    wr(R_STAT, 32'd7);
    rdchk("w1c_all", R_STAT, 32'd0);

    // interrupt
    wr(R_CTRL, 32'd3);
    rdchk("ctrl_ie", R_CTRL, 32'd3);
    pwm_in = 1'b0; tick(5);
    pwm_in = 1'b1; tick(3 + EXTRA);
    rdchk("irq_valid", R_STAT, 32'd1);
    chk("irq_lag", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_set", {31'd0, irq}, 32'd1);

    // W1C on the same edge as a new result: set wins
    pwm_in = 1'b0; tick(5);
    pwm_in = 1'b1; tick(2 + EXTRA);
    wr(R_STAT, 32'd1);
    rdchk("set_wins", R_STAT, 32'd5);
    wr(R_STAT, 32'd7);
    rdchk("w1c_clear", R_STAT, 32'd0);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // 10/10 waveform with a 2-cycle low glitch inside the high phase
    wr(R_CTRL, 32'd1);
    pwm_in = 1'b0; tick(10);
    pwm_in = 1'b1; tick(4);
    pwm_in = 1'b0; tick(2);
    pwm_in = 1'b1; tick(4);
    pwm_in = 1'b0; tick(10);
    pwm_in = 1'b1; tick(3 + EXTRA);
    rdchk("glitch_period", R_PER, GL_PER);
    rdchk("glitch_high", R_HIGH, GL_HI);

    // disable mid-measurement
    wr(R_STAT, 32'd7);
    wr(R_CTRL, 32'd0);
    pwm_in = 1'b0; tick(5);
    pwm_in = 1'b1; tick(5 + EXTRA);
    rdchk("dis_status", R_STAT, 32'd0);
    rdchk("dis_period", R_PER, GL_PER);
    rdchk("dis_ctrl", R_CTRL, 32'd0);

    // counter saturation while held high
    wr(R_CTRL, 32'd1);
    pwm_in = 1'b0; tick(5);
    pwm_in = 1'b1; tick(3 + EXTRA);
    tick(65534);
    rdchk("ovf_not_yet", R_STAT, 32'd0);
    tick();
    rdchk("ovf_status", R_STAT, 32'd2);
    rdchk("ovf_period", R_PER, GL_PER);
    rdchk("ovf_high", R_HIGH, GL_HI);

    // after overflow the block re-arms on the next rise
    pwm_in = 1'b0; tick(5);
    pwm_in = 1'b1; tick(3);
    pwm_in = 1'b0; tick(5);
    pwm_in = 1'b1; tick(3 + EXTRA);
    rdchk("rearm_status", R_STAT, 32'd3);
    rdchk("rearm_period", R_PER, 32'd8);
    rdchk("rearm_high", R_HIGH, 32'd3);

    // asynchronous reset during the low phase
    pwm_in = 1'b0; tick(4 + EXTRA);
    pwm_resetn = 1'b0;
    #1;
    rdchk("arst_ctrl", R_CTRL, 32'd0);
    rdchk("arst_status", R_STAT, 32'd0);
    rdchk("arst_period", R_PER, 32'd0);
    rdchk("arst_high", R_HIGH, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    tick(2);
    pwm_resetn = 1'b1;
    pwm_in = 1'b1; tick(5 + EXTRA);
    rdchk("post_rst_status", R_STAT, 32'd0);
    rdchk("post_rst_period", R_PER, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
